// File: rtl/spike_fifo_arbiter.sv
// Round-robin write arbiter: one pending spike per neuron bank, timestamped at capture,
// drained into a shared event FIFO one word per cycle, with a saturating drop counter.
module spike_fifo_arbiter #(
  parameter int N_REQ      = 8,
  parameter int ID_WIDTH   = 3,
  parameter int TS_WIDTH   = 13,
  parameter int DROP_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             spike,
  input  logic                         tick,
  input  logic                         fifo_full,
  output logic                         fifo_wr,
  output logic [ID_WIDTH+TS_WIDTH-1:0] fifo_data,
  output logic [N_REQ-1:0]             pending,
  output logic [DROP_WIDTH-1:0]        drop_cnt
);

  localparam int CW = DROP_WIDTH + $clog2(N_REQ + 1);

  // Handshake: fifo_wr is a single-cycle write strobe; the word on fifo_data is taken
  // by the FIFO on the rising edge where fifo_wr=1. fifo_wr is never raised while fifo_full=1.

  logic [N_REQ-1:0]      r_pending;
  logic [TS_WIDTH-1:0]   r_ts_reg [N_REQ];
  logic [TS_WIDTH-1:0]   r_ts;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [DROP_WIDTH-1:0] r_drop_cnt;

  logic                  w_valid;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_next_idx;
  logic [ID_WIDTH-1:0]   w_grant_idx;
  logic [ID_WIDTH-1:0]   w_sel;
  logic [N_REQ-1:0]      w_grant_oh;
  logic [N_REQ-1:0]      w_drop_vec;
  logic [CW-1:0]         w_drop_num;
  logic [CW-1:0]         w_drop_sum;
  logic [DROP_WIDTH-1:0] w_drop_next;

  // Search order starts just after the last granted bank.
  always_comb begin
    w_next_idx  = (r_rr_ptr == ID_WIDTH'(N_REQ - 1)) ? '0 : r_rr_ptr + 1'b1;
    w_grant_idx = w_next_idx;
    w_found     = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && r_pending[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_found     = 1'b1;
        w_grant_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_valid    = (|r_pending) & ~fifo_full;
  assign w_sel      = w_valid ? w_grant_idx : w_next_idx;
  assign w_grant_oh = w_valid ? (N_REQ'(1) << w_grant_idx) : '0;
  assign fifo_wr    = w_valid;
  assign fifo_data  = {r_ts_reg[w_sel], w_sel};
  assign pending    = r_pending;
  assign drop_cnt   = r_drop_cnt;

  // A spike on a bank still holding an event is lost unless that bank drains this cycle.
  assign w_drop_vec = spike & r_pending & ~w_grant_oh;

  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_drop_num = w_drop_num + CW'(w_drop_vec[i]);
    end
    w_drop_sum  = CW'(r_drop_cnt) + w_drop_num;
    w_drop_next = (w_drop_sum > CW'({DROP_WIDTH{1'b1}})) ? {DROP_WIDTH{1'b1}}
                                                         : w_drop_sum[DROP_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= '0;
      r_ts       <= '0;
      r_rr_ptr   <= ID_WIDTH'(N_REQ - 1);
      r_drop_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_ts_reg[i] <= '0;
      end
    end else begin
      if (tick) begin
        r_ts <= r_ts + 1'b1;
      end
      if (w_valid) begin
        r_rr_ptr <= w_grant_idx;
      end
      r_drop_cnt <= w_drop_next;
      // Capture takes priority over the grant clear so a same-cycle respike is kept.
      for (int i = 0; i < N_REQ; i++) begin
        if (spike[i] && (!r_pending[i] || w_grant_oh[i])) begin
          r_pending[i] <= 1'b1;
          r_ts_reg[i]  <= r_ts;
        end else if (w_grant_oh[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
// Bench for spike_fifo_arbiter: directed and random stimulus against a queue-based
// reference model; a negedge monitor pops expected event words and checks state.
module tb_spike_fifo_arbiter;

  localparam int N   = 8;
  localparam int TSW = 13;
  localparam int DW  = 16;

  logic          clk;
  logic          reset;
  logic [N-1:0]  spike;
  logic          tick;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data;
  logic [N-1:0]  pending;
  logic [7:0]    drop_cnt;

  spike_fifo_arbiter #(.N_REQ(N), .ID_WIDTH(3), .TS_WIDTH(TSW), .DROP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .spike(spike), .tick(tick), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .pending(pending), .drop_cnt(drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic          exp_wr;
  int            total;
  int            bad;
  bit            run;

  // reference model: state as seen by the DUT during the current cycle
  bit            m_pend [N];
  int            m_tsr  [N];
  int            m_rr;
  int            m_drop;
  int            m_ts;
  logic [N-1:0]  s_spk;
  logic          s_tick;
  logic          s_full;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_tsr[i]  = 0;
    end
    m_rr   = N - 1;
    m_drop = 0;
    m_ts   = 0;
    s_spk  = '0;
    s_tick = 1'b0;
    s_full = 1'b0;
    exp_wr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_grant(input logic full, output bit gv, output int gi);
    gv = 0;
    gi = 0;
    for (int off = 1; off <= N; off++) begin
      if (!gv && m_pend[(m_rr + off) % N]) begin
        gv = 1;
        gi = (m_rr + off) % N;
      end
    end
    if (full) gv = 0;
  endtask

  // advance the model across the edge that consumed the saved inputs
  task automatic model_edge();
    bit gv;
    int gi;
    int drops;
    model_grant(s_full, gv, gi);
    drops = 0;
    if (gv) begin
      m_pend[gi] = 0;
      m_rr = gi;
    end
    for (int i = 0; i < N; i++) begin
      if (s_spk[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1;
          m_tsr[i]  = m_ts;
        end else begin
          drops++;
        end
      end
    end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    if (s_tick) m_ts = (m_ts + 1) % (1 << TSW);
  endtask

  function automatic int next_ts();
    return s_tick ? (m_ts + 1) % (1 << TSW) : m_ts;
  endfunction

  // driver
  task automatic step(input logic [N-1:0] spk, input logic tk, input logic full);
    bit gv;
    int gi;
    logic [2:0] id;
    logic [TSW-1:0] t;
    @(posedge clk);
    #1;
    model_edge();
    spike     = spk;
    tick      = tk;
    fifo_full = full;
    s_spk     = spk;
    s_tick    = tk;
    s_full    = full;
    model_grant(full, gv, gi);
    exp_wr = gv;
    if (gv) begin
      id = gi[2:0];
      t  = m_tsr[gi][TSW-1:0];
      exp_q.push_back({t, id});
    end
  endtask

  task automatic do_reset_mid();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_wr", {31'd0, fifo_wr}, 32'd0);
    check("rst_async_pend", {24'd0, pending}, 32'd0);
    spike     = '0;
    tick      = 1'b0;
    fifo_full = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [DW-1:0] e;
    logic [N-1:0]  mp;
    if (run && !reset) begin
      check("fifo_wr", {31'd0, fifo_wr}, {31'd0, exp_wr});
      if (exp_wr || fifo_wr) begin
        if (exp_q.size() == 0) begin
          check("word_queue", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (fifo_wr && exp_wr) check("fifo_data", {16'd0, fifo_data}, {16'd0, e});
        end
      end
      for (int i = 0; i < N; i++) mp[i] = m_pend[i];
      check("pending", {24'd0, pending}, {24'd0, mp});
      check("drop_cnt", {24'd0, drop_cnt}, m_drop);
    end
  end

  initial begin
    logic [N-1:0] rs;
    total     = 0;
    bad       = 0;
    run       = 0;
    reset     = 1'b1;
    spike     = '0;
    tick      = 1'b0;
    fifo_full = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1;

    // single spike on bank 2 at ts=5
    repeat (5) step('0, 1'b1, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);

    // all banks, then banks 0 and 7
    step(8'hFF, 1'b0, 1'b0);
    repeat (9) step('0, 1'b1, 1'b0);
    step(8'h81, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);

    // full stall with three pending banks
    step(8'h26, 1'b1, 1'b1);
    repeat (10) step('0, 1'b0, 1'b1);
    repeat (5) step('0, 1'b0, 1'b0);

    // respike while full drops; respike on grant cycle is kept
    step(8'h08, 1'b1, 1'b1);
    step(8'h08, 1'b1, 1'b1);
    step(8'h08, 1'b1, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);

    // saturate the drop counter
    step(8'hFF, 1'b0, 1'b1);
    repeat (40) step(8'hFF, 1'b1, 1'b1);
    repeat (10) step('0, 1'b0, 1'b0);

    // timestamp wrap with tick and spike coincident
    for (int k = 0; k < 9000 && next_ts() != (1 << TSW) - 1; k++) step('0, 1'b1, 1'b0);
    step(8'h10, 1'b1, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);

    // async reset during a burst, then bank 5
    step(8'hFF, 1'b1, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);
    do_reset_mid();
    step(8'h20, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);

    // random traffic with one more mid-run reset
    for (int k = 0; k < 1500; k++) begin
      rs = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step(rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if (k == 700) do_reset_mid();
    end
    repeat (12) step('0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_fifo_arbiter.md
# spike_fifo_arbiter

Round-robin write-side arbiter sharing one spike-event FIFO between N_REQ neuron banks of the Poisson neuron array. Latches one pending spike per bank together with its capture timestamp. Grants at most one bank per cycle into the FIFO write port, stalling on FIFO full. Counts spikes lost to per-bank overflow.

## Interface
- N_REQ, 8: number of requesting neuron banks.
- ID_WIDTH, 3: bank-ID field width; 2**ID_WIDTH >= N_REQ required.
- TS_WIDTH, 13: timestamp field width; event word is ID_WIDTH+TS_WIDTH bits (16 by default, matching the FIFO DATA_WIDTH).
- DROP_WIDTH, 8: drop counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- spike  in  N_REQ  per-bank single-cycle spike pulses, sampled on clk.
- tick  in  1  timestep strobe; advances the timestamp counter.
- fifo_full  in  1  FIFO full flag, used combinationally.
- fifo_wr  out  1  FIFO write strobe, combinational from registered state and fifo_full.
- fifo_data  out  ID_WIDTH+TS_WIDTH  event word {ts, id}, with ts in the MSBs.
- pending  out  N_REQ  registered per-bank pending flags.
- drop_cnt  out  DROP_WIDTH  saturating count of dropped spikes.

## Operation
- Registered state:
  - pending[N_REQ]
  - ts_reg[N_REQ] of TS_WIDTH bits
  - ts counter, TS_WIDTH bits
  - rr_ptr (last granted index)
  - drop_cnt
- Timestamp: ts increments by 1 on each clk edge with tick=1 and wraps from 2**TS_WIDTH-1 to 0. A spike sampled in the same cycle as tick captures the pre-increment ts.
- Grant logic (combinational):
  - valid = |pending & ~fifo_full.
  - g = first index with pending set, searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - fifo_wr = valid.
  - fifo_data = {ts_reg[g], g zero-extended to ID_WIDTH}.
  - When valid=0, fifo_data = {ts_reg[rr_ptr+1 mod N_REQ], rr_ptr+1}; the value is don't-care but must be stable and non-X.
- On each clk edge:
  - If valid: pending[g] cleared and rr_ptr <= g.
  - Otherwise rr_ptr and all pending flags hold.
- Capture, per bank i, on spike[i]=1:
  - If pending[i]=0, or pending[i]=1 and bank i is granted this cycle: pending[i] <= 1 and ts_reg[i] <= ts. Capture wins over the grant clear, so no loss.
  - If pending[i]=1 and bank i is not granted: the spike is dropped; ts_reg[i] is unchanged and drop_cnt increments.
  - Multiple drops in one cycle add their popcount to drop_cnt. drop_cnt saturates at 2**DROP_WIDTH-1 and never wraps.
- fifo_full=1: no grant, no state change other than captures, drops and ts.
- The FIFO's own full gating is never relied on: fifo_wr is never asserted while fifo_full=1.

## Timing
- Reset values:
  - pending=0, ts_reg=0, ts=0, drop_cnt=0.
  - rr_ptr=N_REQ-1, so the first grant after reset is the lowest pending index starting from 0.
  - fifo_wr=0 while reset is asserted or immediately after.
- Latency: spike sampled at edge k → pending set after edge k → fifo_wr=1 in cycle k+1 (if granted and not full) → word written at edge k+1. Minimum 1 cycle.
- Throughput: one event per cycle. With all N_REQ banks pending, each is served within N_REQ consecutive non-full cycles.
- fifo_full rising mid-burst: the grant is suppressed in that same cycle and the burst resumes from rr_ptr+1 on the first non-full cycle.
- Reset asserted mid-operation: all state clears asynchronously and pending events are discarded. fifo_wr drops in the same cycle reset asserts.

## Test plan
- Reset then single spike: spike=8'h04 at ts=5 → next cycle fifo_wr=1, fifo_data={13'd5,3'd2}; pending=0 afterwards; drop_cnt=0.
- Round robin with all banks pending: spike=8'hFF for one cycle, fifo_full=0 → fifo_wr high for 8 consecutive cycles with ids 0,1,…,7. Follow with spike=8'h81 → ids 0 then 7.
- Full stall: 3 banks pending and fifo_full=1 for 10 cycles → fifo_wr=0 throughout, pending unchanged. Release → 3 writes in rr order, no losses.
- Drop/collision:
  - Spike bank 3 twice while fifo_full=1 → drop_cnt=1.
  - Spike bank 3 in the same cycle it is granted → no drop; a second event for bank 3 follows with the new timestamp.
  - 300 forced drops with DROP_WIDTH=8 → drop_cnt=255.
- Timestamp wrap and tick coincidence: ts=8191, tick and spike in the same cycle → event carries ts=8191, next ts=0.
- Async reset mid-burst: reset pulse between clock edges during an 8-event burst → fifo_wr=0 immediately, pending=0. The first post-reset spike on bank 5 is granted with id 5 and ts 0.
